// File: rtl/jtopl_pkg.sv
// Shared constants, FSM states and write decode for the OPL register
// scheduler.
package jtopl_pkg;

  localparam logic [7:0] REG_FNUMLO = 8'hA0;
  localparam logic [7:0] REG_FNUMHI = 8'hB0;
  localparam logic [7:0] REG_FBCON  = 8'hC0;
  localparam logic [7:0] REG_RHY    = 8'hBD;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } sched_st_t;

  typedef struct packed {
    logic fnumlo;
    logic fnumhi;
    logic fbcon;
    logic rhy;
    logic op;
  } upd_t;

  function automatic upd_t reg_decode(input logic [7:0] addr);
    upd_t u;
    logic in_ch;
    u = '0;
    in_ch = (addr[3:0] <= 4'h8);
    if (addr == REG_RHY)
      u.rhy = 1'b1;
    else if (addr[7:4] == REG_FNUMLO[7:4])
      u.fnumlo = in_ch;
    else if (addr[7:4] == REG_FNUMHI[7:4])
      u.fnumhi = in_ch;
    else if (addr[7:4] == REG_FBCON[7:4])
      u.fbcon = in_ch;
    else
      u.op = 1'b1;
    return u;
  endfunction

  // Block/key-on and rhythm writes carry edges that must never merge.
  function automatic logic keyon_reg(input logic [7:0] addr);
    return ((addr[7:4] == REG_FNUMHI[7:4]) && (addr[3:0] <= 4'h8))
        || (addr == REG_RHY);
  endfunction

endpackage

// File: rtl/jtopl_reg_fifo.sv
// Generic synchronous FIFO with a rewrite port on the newest entry.
module jtopl_reg_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         tail_we,
  input  logic [W-1:0] tail_din,
  output logic [W-1:0] dout,
  output logic [W-1:0] tail_dout,
  output logic         full,
  output logic         empty,
  output logic         last
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_tail;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign last   = (r_cnt == (AW+1)'(1));
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign w_tail = r_wr - 1'b1;

  assign dout      = r_mem[r_rd];
  assign tail_dout = r_mem[w_tail];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr] <= din;
    else if (tail_we)
      r_mem[w_tail] <= tail_din;
  end

endmodule

// File: rtl/jtopl_reg_sched.sv
// Host-write scheduler: buffers CPU writes and replays them cen-paced.
// Optional: JTOPL_REGSCHED_COALESCE_EN merges repeats of the newest entry.
module jtopl_reg_sched
  import jtopl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       wr,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic       ovf_clr,
  output logic [3:0] up_ch,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_fbcon,
  output logic       up_rhy,
  output logic       up_op,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_dout,
  output logic       busy,
  output logic       full,
  output logic       ovf
);

  localparam logic [3:0] GAP_W = 4'(GAP);

  sched_st_t   r_state;
  logic [3:0]  r_cnt;
  upd_t        r_up;
  logic [7:0]  r_sel_addr;
  logic [7:0]  r_addr;
  logic [7:0]  r_dout;
  logic        r_busy;
  logic        r_ovf;

  logic        w_push;
  logic        w_pop;
  logic        w_coal;
  logic        w_accept;
  logic        w_drop;
  logic        w_empty;
  logic        w_full;
  logic        w_last;
  logic [15:0] w_head;
  logic [15:0] w_tail;

  assign w_push = wr & a0;
  assign w_pop  = cen & (r_state == IDLE) & ~w_empty;

`ifdef JTOPL_REGSCHED_COALESCE_EN
  assign w_coal = w_push & ~w_empty
                & (w_tail[15:8] == r_sel_addr)
                & ~keyon_reg(r_sel_addr)
                & ~(w_pop & w_last);
`else
  logic w_unused_tail;
  assign w_unused_tail = ^{w_tail, w_last};
  assign w_coal = 1'b0;
`endif

  assign w_accept = w_push & ~w_coal & (~w_full | w_pop);
  assign w_drop   = w_push & ~w_coal & w_full & ~w_pop;

  jtopl_reg_fifo #(
    .W     (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_accept),
    .din       ({r_sel_addr, din}),
    .pop       (w_pop),
    .tail_we   (w_coal),
    .tail_din  ({r_sel_addr, din}),
    .dout      (w_head),
    .tail_dout (w_tail),
    .full      (w_full),
    .empty     (w_empty),
    .last      (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_addr <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (wr & ~a0) r_sel_addr <= din;
      if (w_drop)
        r_ovf <= 1'b1;
      else if (ovf_clr)
        r_ovf <= 1'b0;
      r_busy <= ~w_empty | (r_state != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_up    <= '0;
      r_addr  <= '0;
      r_dout  <= '0;
    end else if (cen) begin
      unique case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_addr  <= w_head[15:8];
            r_dout  <= w_head[7:0];
            r_up    <= reg_decode(w_head[15:8]);
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_up <= '0;
          if (GAP == 0) begin
            r_state <= IDLE;
          end else begin
            r_cnt   <= GAP_W;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt <= 4'd1) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign up_ch     = r_addr[3:0];
  assign up_fnumlo = r_up.fnumlo;
  assign up_fnumhi = r_up.fnumhi;
  assign up_fbcon  = r_up.fbcon;
  assign up_rhy    = r_up.rhy;
  assign up_op     = r_up.op;
  assign reg_addr  = r_addr;
  assign reg_dout  = r_dout;
  assign busy      = r_busy;
  assign full      = w_full;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_jtopl_reg_sched.sv
// Scoreboard bench for jtopl_reg_sched: queue model of the FIFO plus a
// cen-edge monitor comparing every issued strobe.
module tb_jtopl_reg_sched;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;

  logic       clk = 0;
  logic       rst = 0;
  logic       cen = 0;
  logic       wr = 0;
  logic       a0 = 0;
  logic [7:0] din = 0;
  logic       ovf_clr = 0;
  logic [3:0] up_ch;
  logic       up_fnumlo, up_fnumhi, up_fbcon, up_rhy, up_op;
  logic [7:0] reg_addr, reg_dout;
  logic       busy, full, ovf;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_seen = 0;
  int   cen_div = 4;
  bit   cen_on = 0;
  bit   mon_en = 1;
  ent_t exp_q[$];
  ent_t m_fifo[$];
  logic [7:0] m_sel = 8'h00;
  bit   m_ovf = 0;

  jtopl_reg_sched #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .cen(cen), .wr(wr), .a0(a0), .din(din),
    .ovf_clr(ovf_clr), .up_ch(up_ch), .up_fnumlo(up_fnumlo),
    .up_fnumhi(up_fnumhi), .up_fbcon(up_fbcon), .up_rhy(up_rhy),
    .up_op(up_op), .reg_addr(reg_addr), .reg_dout(reg_dout),
    .busy(busy), .full(full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin : cen_gen
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      if (cen_on) begin
        c++;
        cen = (c >= cen_div);
        if (cen) c = 0;
      end else begin
        cen = 0;
        c = 0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Strobe vector {fnumlo,fnumhi,fbcon,rhy,op} straight from address ranges.
  function automatic logic [4:0] kind(input logic [7:0] a);
    int v, lo;
    v = int'(a);
    lo = v % 16;
    if (v < 'hA0 || v > 'hCF) return 5'b00001;
    if (v == 'hBD) return 5'b00010;
    if (lo > 8) return 5'b00000;
    if (v / 16 == 'hA) return 5'b10000;
    if (v / 16 == 'hB) return 5'b01000;
    return 5'b00100;
  endfunction

  function automatic bit no_merge(input logic [7:0] a);
    return (a >= 8'hB0 && a <= 8'hB8) || a == 8'hBD;
  endfunction

  initial begin : mon
    logic [4:0] stb;
    ent_t e;
    int gap;
    bit had;
    gap = 0;
    had = 0;
    forever begin
      @(negedge clk);
      stb = {up_fnumlo, up_fnumhi, up_fbcon, up_rhy, up_op};
      if (rst) begin
        had = 0;
        gap = 0;
      end else begin
        if (|stb) n_seen++;
        if (mon_en && cen) begin
          if (|stb) begin
            chk("onehot", $countones(stb), 1);
            if (had) chk("gap_ge", int'(gap >= GAP), 1);
            chk("issue_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("strobe", int'(stb), int'(kind(e.a)));
              chk("reg_addr", int'(reg_addr), int'(e.a));
              chk("reg_dout", int'(reg_dout), int'(e.d));
              chk("up_ch", int'(up_ch), int'(e.a) % 16);
            end
            had = 1;
            gap = 0;
          end else begin
            gap++;
          end
        end
      end
    end
  end

  task automatic host_wr(input bit isdata, input logic [7:0] v);
    @(posedge clk);
    #1;
    wr = 1;
    a0 = isdata;
    din = v;
    @(posedge clk);
    #1;
    wr = 0;
    if (!isdata) m_sel = v;
  endtask

  // Data write with cen frozen: the model FIFO never pops.
  task automatic frozen_data(input logic [7:0] d);
    bit coal;
    coal = 0;
`ifdef JTOPL_REGSCHED_COALESCE_EN
    if (m_fifo.size() > 0 && m_fifo[m_fifo.size()-1].a == m_sel
        && !no_merge(m_sel)) begin
      m_fifo[m_fifo.size()-1].d = d;
      coal = 1;
    end
`endif
    if (!coal) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back({m_sel, d});
      else m_ovf = 1;
    end
    host_wr(1, d);
  endtask

  task automatic release_frozen(input int div);
    ent_t e;
    while (m_fifo.size() > 0) begin
      e = m_fifo.pop_front();
      if (kind(e.a) != 0) exp_q.push_back(e);
    end
    cen_div = div;
    cen_on = 1;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    repeat (2) @(posedge clk);
    while ((exp_q.size() != 0 || busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_drain_in_time"}, int'(t < 5000), 1);
    chk({nm, "_busy_end"}, int'(busy), 0);
    chk({nm, "_full_end"}, int'(full), 0);
    exp_q.delete();
  endtask

  task automatic clear_ovf();
    @(posedge clk);
    #1;
    ovf_clr = 1;
    @(posedge clk);
    #1;
    ovf_clr = 0;
    m_ovf = 0;
    chk("ovf_cleared", int'(ovf), 0);
  endtask

  function automatic logic [7:0] rnd_addr();
    case ($urandom_range(0, 6))
      0: return 8'hA0 + 8'($urandom_range(0, 8));
      1: return 8'hB0 + 8'($urandom_range(0, 8));
      2: return 8'hC0 + 8'($urandom_range(0, 8));
      3: return 8'hBD;
      4: return 8'hC9 + 8'($urandom_range(0, 6));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin : stim
    logic [7:0] a, d, last_a;
    int t, seen0, n;

    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", int'({up_ch, up_fnumlo, up_fnumhi, up_fbcon,
        up_rhy, up_op, reg_addr, reg_dout}), 0);
    chk("rst_flags", int'({busy, full, ovf}), 0);
    rst = 0;
    repeat (2) @(posedge clk);

    // Single fnumlo write and busy release timing.
    cen_div = 4;
    cen_on = 1;
    host_wr(0, 8'hA3);
    exp_q.push_back({8'hA3, 8'h55});
    host_wr(1, 8'h55);
    t = 0;
    while (!(cen && up_fnumlo) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t1_strobe_seen", int'(t < 200), 1);
    chk("t1_up_ch", int'(up_ch), 3);
    n = 0;
    while (n < 2) begin
      @(negedge clk);
      if (cen) n++;
      if (cen && n == 1) chk("t1_strobe_dropped", int'(up_fnumlo), 0);
    end
    chk("t1_busy_before_e3", int'(busy), 1);
    do @(negedge clk); while (!cen);
    chk("t1_busy_after_e3", int'(busy), 0);
    drain("t1");

    // Back-to-back writes with a repeated key-on register.
    host_wr(0, 8'hB0);
    exp_q.push_back({8'hB0, 8'h32});
    host_wr(1, 8'h32);
    exp_q.push_back({8'hB0, 8'h12});
    host_wr(1, 8'h12);
    host_wr(0, 8'hC8);
    exp_q.push_back({8'hC8, 8'h0F});
    host_wr(1, 8'h0F);
    drain("t2");

    // Overflow with cen frozen.
    cen_on = 0;
    for (int i = 0; i < 6; i++) begin
      host_wr(0, 8'hA0 + 8'(i));
      frozen_data(8'h40 + 8'(i));
    end
    chk("t3_full", int'(full), 1);
    chk("t3_ovf", int'(ovf), int'(m_ovf));
    release_frozen(4);
    drain("t3");
    chk("t3_ovf_sticky", int'(ovf), 1);
    clear_ovf();

    // Silent in-range addresses still occupy issue slots.
    cen_on = 0;
    host_wr(0, 8'hAB);
    frozen_data(8'h01);
    host_wr(0, 8'hBE);
    frozen_data(8'h02);
    host_wr(0, 8'h20);
    frozen_data(8'h03);
    release_frozen(2);
    drain("t4");
    chk("t4_last_addr", int'(reg_addr), 8'h20);

    // Coalescing candidate: same register twice while frozen.
    cen_on = 0;
    host_wr(0, 8'hA1);
    frozen_data(8'h10);
    frozen_data(8'h20);
    release_frozen(3);
    drain("t6");

    // Asynchronous reset while up_fbcon is high.
    mon_en = 0;
    cen_on = 0;
    host_wr(0, 8'hC2);
    host_wr(1, 8'h11);
    host_wr(0, 8'hC3);
    host_wr(1, 8'h22);
    cen_div = 4;
    cen_on = 1;
    t = 0;
    while (!up_fbcon && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t5_fbcon_seen", int'(t < 200), 1);
    #2 rst = 1;
    #1;
    chk("t5_async_out", int'({up_ch, up_fnumlo, up_fnumhi, up_fbcon,
        up_rhy, up_op, reg_addr, reg_dout}), 0);
    chk("t5_async_flags", int'({busy, full, ovf}), 0);
    repeat (2) @(posedge clk);
    #3 rst = 0;
    m_sel = 8'h00;
    m_fifo.delete();
    exp_q.delete();
    seen0 = n_seen;
    repeat (60) @(posedge clk);
    chk("t5_no_strobe_after", n_seen - seen0, 0);
    chk("t5_idle_after", int'(busy), 0);
    mon_en = 1;
    exp_q.push_back({8'h00, 8'h77});
    host_wr(1, 8'h77);
    drain("t5_seladdr");

    // Randomized frozen and running bursts.
    last_a = 8'h00;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        cen_on = 0;
        n = $urandom_range(1, 7);
        host_wr(0, rnd_addr());
        for (int k = 0; k < n; k++) begin
          if ($urandom_range(0, 1) == 0) host_wr(0, rnd_addr());
          frozen_data(8'($urandom_range(0, 255)));
        end
        chk("rf_full", int'(full), int'(m_fifo.size() == DEPTH));
        chk("rf_ovf", int'(ovf), int'(m_ovf));
        release_frozen($urandom_range(1, 4));
        drain("rf");
        if (m_ovf) clear_ovf();
      end else begin
        cen_div = $urandom_range(1, 4);
        cen_on = 1;
        n = $urandom_range(1, DEPTH);
        for (int k = 0; k < n; k++) begin
          do a = rnd_addr(); while (a == last_a);
          d = 8'($urandom_range(0, 255));
          host_wr(0, a);
          if (kind(a) != 0) exp_q.push_back({a, d});
          host_wr(1, d);
          last_a = a;
        end
        drain("rr");
        chk("rr_ovf", int'(ovf), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
